// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - multi-channel synchronised, glitch-filtered edge detector with sticky flags
// Each channel: sync chain -> stability filter -> mode-qualified edge pulse -> sticky flag; irq ORs stickies.
module multi_edge_detector #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   data,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   edge_detect,
  output logic [CHANNELS-1:0]   edge_type,
  output logic [CHANNELS-1:0]   sticky,
  output logic                  irq
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CHANNELS-1:0] sticky_next;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   level_q;
      logic                   pulse_q;
      logic                   type_q;
      logic                   sticky_q;
      logic                   s;
      logic                   differ;
      logic                   accept;
      logic                   hit;

      assign s      = sync_q[SYNC_STAGES-1];
      assign differ = s ^ level_q;
      assign accept = differ && (cnt_q == CNT_LAST);
      // mode bit 0 enables rising (level 0->1), bit 1 enables falling (level 1->0)
      assign hit    = accept && (level_q ? mode[2*i+1] : mode[2*i]);
      assign sticky_next[i] = hit | (sticky_q & ~clear[i]);

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          sync_q   <= '0;
          cnt_q    <= '0;
          level_q  <= 1'b0;
          pulse_q  <= 1'b0;
          type_q   <= 1'b0;
          sticky_q <= 1'b0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], data[i]};
          if (!differ) begin
            cnt_q <= '0;
          end else if (accept) begin
            cnt_q   <= '0;
            level_q <= ~level_q;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
          pulse_q <= hit;
          if (hit) begin
            type_q <= ~level_q;
          end
          sticky_q <= sticky_next[i];
        end
      end

      assign level[i]       = level_q;
      assign edge_detect[i] = pulse_q;
      assign edge_type[i]   = type_q;
      assign sticky[i]      = sticky_q;
    end
  endgenerate

  // irq is registered from the same next-state as sticky so the two always agree
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |sticky_next;
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb/tb_multi_edge_detector.sv - scoreboard bench for multi_edge_detector against a sample-window model
module tb_multi_edge_detector;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FC = 3;

  typedef struct packed {
    logic [CH-1:0] lv;
    logic [CH-1:0] ed;
    logic [CH-1:0] et;
    logic [CH-1:0] st;
    logic          irq;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [CH-1:0]   d_r = '0;
  logic [2*CH-1:0] m_r = '0;
  logic [CH-1:0]   c_r = '0;
  logic [CH-1:0]   level, edge_detect, edge_type, sticky;
  logic            irq;

  int checks = 0;
  int errors = 0;

  exp_t          exp_q[$];
  logic [CH-1:0] dq[$];
  logic [CH-1:0] sq[$];
  logic [CH-1:0] m_lv, m_et, m_st;

  multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC)) dut (
    .clock(clock), .reset_n(reset_n), .data(d_r), .mode(m_r), .clear(c_r),
    .level(level), .edge_detect(edge_detect), .edge_type(edge_type),
    .sticky(sticky), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    for (int k = 0; k < SS; k++) dq.push_back('0);
    sq.delete();
    m_lv = '0; m_et = '0; m_st = '0;
  endtask

  // A channel's level flips once its last FC synchronised samples all disagree with it.
  task automatic model_update();
    exp_t          e;
    logic [CH-1:0] s, v, pulse;
    bit            all_diff;
    pulse = '0;
    if (!reset_n) begin
      model_reset();
    end else begin
      dq.push_back(d_r);
      s = dq[dq.size() - 1 - SS];
      if (dq.size() > SS + 1) void'(dq.pop_front());
      sq.push_back(s);
      if (sq.size() > FC) void'(sq.pop_front());
      for (int c = 0; c < CH; c++) begin
        all_diff = (sq.size() == FC);
        for (int k = 0; k < sq.size(); k++) begin
          v = sq[k];
          if (v[c] == m_lv[c]) all_diff = 0;
        end
        if (all_diff) begin
          m_lv[c] = ~m_lv[c];
          if ((m_lv[c] && m_r[2*c]) || (!m_lv[c] && m_r[2*c+1])) begin
            pulse[c] = 1'b1;
            m_et[c]  = m_lv[c];
          end
        end
        m_st[c] = pulse[c] | (m_st[c] & ~c_r[c]);
      end
    end
    e.lv = m_lv; e.ed = pulse; e.et = m_et; e.st = m_st; e.irq = |m_st;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      model_update();
      #2;
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("level", 32'(level), 32'(e.lv));
      check("edge_detect", 32'(edge_detect), 32'(e.ed));
      check("edge_type", 32'(edge_type), 32'(e.et));
      check("sticky", 32'(sticky), 32'(e.st));
      check("irq", 32'(irq), 32'(e.irq));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    model_reset();
    step(3);
    reset_n = 1'b1;
    m_r = 8'b11_10_11_01;

    // rise on channel 0 (rise-only mode)
    d_r[0] = 1'b1; step(8);
    // 2-cycle glitch on channel 1 must be filtered out
    d_r[1] = 1'b1; step(2); d_r[1] = 1'b0; step(8);
    // channel 2 fall-only: rise then fall 10 cycles later
    d_r[2] = 1'b1; step(10); d_r[2] = 1'b0; step(8);
    // channel 3 toggling, both edges then off
    repeat (4) begin d_r[3] = ~d_r[3]; step(8); end
    m_r[7:6] = 2'b00;
    repeat (4) begin d_r[3] = ~d_r[3]; step(8); end

    // clear coincident with a new pulse: set wins
    m_r[1:0] = 2'b11;
    d_r[0] = 1'b0; step(4);
    c_r[0] = 1'b1; step(1); c_r[0] = 1'b0;
    @(negedge clock); #1;
    check("coincident_pulse", 32'(edge_detect[0]), 32'd1);
    check("coincident_sticky", 32'(sticky[0]), 32'd1);
    c_r = '1; step(1); c_r = '0;
    @(negedge clock); #1;
    check("cleared_irq", 32'(irq), 32'd0);

    // reset mid-filter, then latency of the rising edge after release
    step(10);
    d_r[0] = 1'b1; step(3);
    @(negedge clock); #1;
    reset_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("async_reset_outputs", {level, edge_detect, edge_type, sticky, 15'd0, irq}, 32'd0);
    step(2);
    reset_n = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      step(1); n++;
      @(negedge clock); #1;
      if (edge_detect[0]) seen = 1;
    end
    check("post_reset_latency", 32'(n), 32'd5);
    check("post_reset_type", 32'(edge_type[0]), 32'd1);

    // randomized phase
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0) d_r[c] = ~d_r[c];
        c_r[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 15) == 0) m_r = 8'($urandom);
      step(1);
    end
    c_r = '0;
    step(2);
    @(negedge clock); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
